// File: rtl/spmv_pkg.sv
// Shared constants and types for the Val-array fetch engine.
//   AXI_BURST_INCR / AXI_SIZE_32B / AXI_RESP_OKAY : fixed AXI encodings
//   PAGE_BEATS    : 32-byte beats in one 4 KB page
//   fetch_state_t : fetch FSM state encoding
//   min_u32       : unsigned minimum used by the burst sizing logic
package spmv_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         PAGE_BEATS     = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/spmv_val_fetch_if.sv
// Bus bundle for the Val fetch engine: AXI read channels (AR/R) towards the
// Val crossbar plus the AXI-Stream output towards the multiply datapath.
//   master : the fetch engine (drives AR, rready and the stream)
//   slave  : the memory side and the stream consumer
interface spmv_val_fetch_if
  import spmv_pkg::*;
#(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 256
);

  logic [ADDR_W-1:0] m_axi_Val_araddr;
  logic [7:0]        m_axi_Val_arlen;
  logic [2:0]        m_axi_Val_arsize;
  logic [1:0]        m_axi_Val_arburst;
  logic              m_axi_Val_arvalid;
  logic              m_axi_Val_arready;
  logic [DATA_W-1:0] m_axi_Val_rdata;
  logic [1:0]        m_axi_Val_rresp;
  logic              m_axi_Val_rlast;
  logic              m_axi_Val_rvalid;
  logic              m_axi_Val_rready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    output m_axi_Val_araddr, m_axi_Val_arlen, m_axi_Val_arsize, m_axi_Val_arburst,
           m_axi_Val_arvalid, m_axi_Val_rready,
           m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axi_Val_arready, m_axi_Val_rdata, m_axi_Val_rresp, m_axi_Val_rlast,
           m_axi_Val_rvalid, m_axis_tready
  );

  modport slave (
    input  m_axi_Val_araddr, m_axi_Val_arlen, m_axi_Val_arsize, m_axi_Val_arburst,
           m_axi_Val_arvalid, m_axi_Val_rready,
           m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axi_Val_arready, m_axi_Val_rdata, m_axi_Val_rresp, m_axi_Val_rlast,
           m_axi_Val_rvalid, m_axis_tready
  );

endinterface

// File: rtl/spmv_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
//   clk, rst : clock, synchronous active-high flush
//   push     : write wdata (accepted when not full, or when full and popping)
//   pop      : consume the head word (ignored when empty)
//   rdata    : head word, valid whenever empty is low
//   empty    : no words stored
//   count    : words stored, 0..DEPTH
// A word written into an empty FIFO appears on rdata the following cycle;
// there is no combinational path from wdata to rdata. DEPTH must be a power
// of two so the pointers wrap naturally.
module spmv_sync_fifo
  import spmv_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // when full, the slot being freed by the pop is reused by the push
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spmv_val_fetch.sv
// Val-array read master: splits a job of num_beats 32-byte beats into INCR
// bursts that never cross a 4 KB page, limits outstanding bursts and reserves
// buffer space per burst so R is never back-pressured, and streams the beats
// out through an FWFT FIFO with tlast on the final beat of the job.
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle job request (ignored while busy)
//   base_addr       : byte address of the first beat (low 5 bits ignored)
//   num_beats       : job length in beats (0 completes immediately)
//   busy            : job in progress
//   done            : one-cycle pulse after the last beat leaves the stream
//   err             : sticky, a non-OKAY rresp was seen since the last start
//   bus             : AXI AR/R master and AXI-Stream source
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no job; waiting for start
// ST_ISSUE | issuing AR bursts while credits and outstanding slots allow
// ST_DRAIN | all bursts issued; waiting for the tlast stream handshake
module spmv_val_fetch
  import spmv_pkg::*;
#(
  parameter int ADDR_W          = 48,
  parameter int DATA_W          = 256,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       num_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  spmv_val_fetch_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  fetch_state_t      state;
  fetch_state_t      state_nx;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       remaining;
  logic [31:0]       total;
  logic [31:0]       popped;
  logic [CW-1:0]     inflight;
  logic [OW-1:0]     outstanding;

  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;

  logic [31:0]       page_left;
  logic [31:0]       burst_len;
  logic [33:0]       credit_need;
  logic              can_issue;
  logic [8:0]        ar_beats;
  logic              ar_hs;
  logic              r_hs;
  logic              s_hs;
  logic              tlast_int;
  logic              idle_start;
  logic              job_accept;
  logic              zero_job;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign idle_start = start && (state == ST_IDLE);
  assign job_accept = idle_start && (num_beats != 32'd0);
  assign zero_job   = idle_start && (num_beats == 32'd0);

  // beats left before the next 4 KB page boundary, 1..128
  assign page_left   = 32'(PAGE_BEATS) - 32'(addr[11:5]);
  assign burst_len   = min_u32(min_u32(remaining, 32'(MAX_BURST)), page_left);
  // every beat already buffered or requested holds a FIFO slot
  assign credit_need = 34'(fifo_count) + 34'(inflight) + 34'(burst_len);
  assign can_issue   = (state == ST_ISSUE) && !arvalid_q
                    && (outstanding < OW'(MAX_OUTSTANDING))
                    && (credit_need <= 34'(FIFO_DEPTH));

  assign ar_beats  = {1'b0, arlen_q} + 9'd1;
  assign ar_hs     = arvalid_q && bus.m_axi_Val_arready;
  assign r_hs      = bus.m_axi_Val_rvalid && bus.m_axi_Val_rready;
  assign s_hs      = bus.m_axis_tvalid && bus.m_axis_tready;
  assign tlast_int = bus.m_axis_tvalid && (popped == total - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (job_accept) state_nx = ST_ISSUE;
      ST_ISSUE: if (ar_hs && (remaining == 32'(ar_beats))) state_nx = ST_DRAIN;
      ST_DRAIN: if (s_hs && tlast_int) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      remaining   <= '0;
      total       <= '0;
      popped      <= '0;
      inflight    <= '0;
      outstanding <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= zero_job || (s_hs && tlast_int);

      if (job_accept) begin
        addr      <= base_addr & ~ADDR_W'(31);
        remaining <= num_beats;
        total     <= num_beats;
        popped    <= '0;
      end

      if (idle_start) begin
        err <= 1'b0;
      end else if (r_hs && (bus.m_axi_Val_rresp != AXI_RESP_OKAY)) begin
        err <= 1'b1;
      end

      // can_issue requires !arvalid_q, so launch and handshake never coincide
      if (can_issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr;
        arlen_q   <= 8'(burst_len - 32'd1);
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
        addr      <= addr + (ADDR_W'(ar_beats) << 5);
        remaining <= remaining - 32'(ar_beats);
      end

      inflight <= inflight + (ar_hs ? CW'(ar_beats) : CW'(0))
                           - (r_hs ? CW'(1) : CW'(0));
      outstanding <= outstanding + (ar_hs ? OW'(1) : OW'(0))
                                 - ((r_hs && bus.m_axi_Val_rlast) ? OW'(1) : OW'(0));

      if (s_hs) popped <= popped + 32'd1;
    end
  end

  spmv_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_hs),
    .wdata (bus.m_axi_Val_rdata),
    .pop   (s_hs),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.m_axi_Val_araddr  = araddr_q;
  assign bus.m_axi_Val_arlen   = arlen_q;
  assign bus.m_axi_Val_arsize  = AXI_SIZE_32B;
  assign bus.m_axi_Val_arburst = AXI_BURST_INCR;
  assign bus.m_axi_Val_arvalid = arvalid_q;
  assign bus.m_axi_Val_rready  = busy;
  assign bus.m_axis_tdata      = fifo_rdata;
  assign bus.m_axis_tvalid     = !fifo_empty;
  assign bus.m_axis_tlast      = tlast_int;

endmodule
